// File: rtl/shuffle_pkg.sv
// Shared types and helpers for the inner-shuffle read address generator.
package shuffle_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } agen_state_e;

   function automatic int tile_words(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/shuffle_rd_agen_wrap_ctr.sv
// Increment-with-wrap counter: counts 0..MAX, wraps to 0 on an increment at MAX.
module wrap_ctr #(
   parameter int MAX = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_max_o
);

   localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign at_max_o = (cnt_q == W'(MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = at_max_o ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/shuffle_rd_agen.sv
// Column-major read address generator over a double-banked tile buffer, with
// bank release driven by the returning read-data beats.
module shuffle_rd_agen
   import shuffle_pkg::*;
#(
   parameter  int ROWS  = 4,
   parameter  int COLS  = 8,
   localparam int TILE  = tile_words(ROWS, COLS),
   localparam int DEPTH = 2 * TILE,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          tile_vld_i,
   output logic          tile_rdy_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          rd_req_vld_o,
   input  logic          rd_req_rdy_i,
   input  logic          rd_dat_vld_i,
   input  logic          rd_dat_rdy_i,
   output logic          rd_last_o,
   output logic          free_vld_o,
   output logic          free_bank_o,
   output logic          err_o
);

   localparam logic [AW-1:0] ROW_STEP = AW'(COLS);
   // Distance from the bottom row of a column back to its top row.
   localparam logic [AW-1:0] COL_BACK = AW'((ROWS - 1) * COLS);

   function automatic logic [AW-1:0] bank_base(input logic b);
      return b ? AW'(TILE) : '0;
   endfunction

   agen_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          iss_bank_q, iss_bank_d;
   logic          pend_q, pend_d;
   logic [1:0]    infl_q, infl_d;
   logic          rel_bank_q;
   logic          free_vld_q, free_bank_q;
   logic          err_q;

   logic accept, fire, last, beat, beat_ok, release_bank;
   logic ctr_clr, r_max, c_max, beat_max;

   assign tile_rdy_o   = (infl_q < 2'd2) && !rst_i;
   assign rd_req_vld_o = (state_q == ISSUE);
   assign rd_addr_o    = addr_q;
   assign last         = r_max && c_max;
   assign rd_last_o    = rd_req_vld_o && last;
   assign free_vld_o   = free_vld_q;
   assign free_bank_o  = free_bank_q;
   assign err_o        = err_q;

   assign accept       = tile_vld_i && tile_rdy_o;
   assign fire         = rd_req_vld_o && rd_req_rdy_i;
   assign beat         = rd_dat_vld_i && rd_dat_rdy_i;
   // Beats with nothing in flight are protocol errors and never advance the count.
   assign beat_ok      = beat && (infl_q != 2'd0);
   assign release_bank = beat_ok && beat_max;

   wrap_ctr #(.MAX(ROWS - 1)) u_row_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (ctr_clr),
      .inc_i    (fire),
      .at_max_o (r_max)
   );

   wrap_ctr #(.MAX(COLS - 1)) u_col_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (ctr_clr),
      .inc_i    (fire && r_max),
      .at_max_o (c_max)
   );

   wrap_ctr #(.MAX(TILE - 1)) u_beat_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (1'b0),
      .inc_i    (beat_ok),
      .at_max_o (beat_max)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      iss_bank_d = iss_bank_q;
      pend_d     = pend_q;
      ctr_clr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ISSUE;
               addr_d  = bank_base(iss_bank_q);
               ctr_clr = 1'b1;
            end
         end
         ISSUE: begin
            if (fire && last) begin
               // A queued (or just-arriving) tile starts on the other bank with no bubble.
               iss_bank_d = ~iss_bank_q;
               addr_d     = bank_base(~iss_bank_q);
               if (pend_q || accept)
                  pend_d = 1'b0;
               else
                  state_d = IDLE;
            end else begin
               if (accept)
                  pend_d = 1'b1;
               if (fire)
                  addr_d = r_max ? (addr_q - COL_BACK + AW'(1)) : (addr_q + ROW_STEP);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      infl_d = infl_q;
      unique case ({accept, release_bank})
         2'b10:   infl_d = infl_q + 2'd1;
         2'b01:   infl_d = infl_q - 2'd1;
         default: infl_d = infl_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         iss_bank_q  <= 1'b0;
         pend_q      <= 1'b0;
         infl_q      <= 2'd0;
         rel_bank_q  <= 1'b0;
         free_vld_q  <= 1'b0;
         free_bank_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         iss_bank_q  <= iss_bank_d;
         pend_q      <= pend_d;
         infl_q      <= infl_d;
         free_vld_q  <= release_bank;
         free_bank_q <= rel_bank_q;
         if (release_bank)
            rel_bank_q <= ~rel_bank_q;
         err_q       <= err_q | (beat && (infl_q == 2'd0));
      end
   end

endmodule

// File: tb/tb_shuffle_rd_agen.sv
// Directed scoreboard bench for shuffle_rd_agen with a 2x3 tile.
module tb_shuffle_rd_agen;

   localparam int ROWS = 2;
   localparam int COLS = 3;
   localparam int TILE = ROWS * COLS;
   localparam int AW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tile_vld = 1'b0;
   logic          tile_rdy;
   logic [AW-1:0] rd_addr;
   logic          rd_req_vld;
   logic          rd_req_rdy = 1'b0;
   logic          rd_dat_vld = 1'b0;
   logic          rd_dat_rdy = 1'b0;
   logic          rd_last;
   logic          free_vld;
   logic          free_bank;
   logic          err;

   int total = 0;
   int bad   = 0;
   int exp_addr[$];
   int exp_last[$];
   int exp_free[$];
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr  = '0;

   always #5 clk = ~clk;

   shuffle_rd_agen #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tile_vld_i   (tile_vld),
      .tile_rdy_o   (tile_rdy),
      .rd_addr_o    (rd_addr),
      .rd_req_vld_o (rd_req_vld),
      .rd_req_rdy_i (rd_req_rdy),
      .rd_dat_vld_i (rd_dat_vld),
      .rd_dat_rdy_i (rd_dat_rdy),
      .rd_last_o    (rd_last),
      .free_vld_o   (free_vld),
      .free_bank_o  (free_bank),
      .err_o        (err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tile(input int bank);
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++) begin
            exp_addr.push_back(bank * TILE + r * COLS + c);
            exp_last.push_back((c == COLS - 1 && r == ROWS - 1) ? 1 : 0);
         end
   endtask

   task automatic drain(output int n);
      n = 0;
      while (exp_addr.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (exp_addr.size() != 0)
         chk("drain_timeout", exp_addr.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_addr.delete();
      exp_last.delete();
      exp_free.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Scoreboard: pops expected requests/releases as the DUT produces them.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_vld", rd_req_vld, 1);
            chk("hold_addr", rd_addr, prev_addr);
         end
         if (rd_req_vld && rd_req_rdy) begin
            if (exp_addr.size() == 0)
               chk("extra_fire", rd_addr, -1);
            else begin
               chk("addr", rd_addr, exp_addr.pop_front());
               chk("last", rd_last, exp_last.pop_front());
            end
         end
         if (free_vld) begin
            if (exp_free.size() == 0)
               chk("extra_free", free_bank, -1);
            else
               chk("free_bank", free_bank, exp_free.pop_front());
         end
      end
      prev_stall = !rst && rd_req_vld && !rd_req_rdy;
      prev_addr  = rd_addr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int beats;

      // Reset state
      tick();
      chk("rst_tile_rdy", tile_rdy, 0);
      chk("rst_req_vld", rd_req_vld, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_last", rd_last, 0);
      chk("rst_free", free_vld, 0);
      chk("rst_err", err, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_tile_rdy", tile_rdy, 1);

      // T1: single tile, always ready
      rd_req_rdy = 1'b1;
      tile_vld = 1'b1;
      push_tile(0);
      tick();
      tile_vld = 1'b0;
      chk("t1_first_vld", rd_req_vld, 1);
      chk("t1_first_addr", rd_addr, 0);
      drain(n);
      chk("t1_cycles", n, TILE);
      chk("t1_idle", rd_req_vld, 0);

      // T2: two back-to-back tiles from bank 0
      do_reset();
      tile_vld = 1'b1;
      push_tile(0);
      push_tile(1);
      tick();
      tick();
      tile_vld = 1'b0;
      chk("t2_tile_rdy_full", tile_rdy, 0);
      drain(n);
      chk("t2_no_bubble", n, 2 * TILE - 1);
      chk("t2_idle", rd_req_vld, 0);
      chk("t2_still_full", tile_rdy, 0);

      // T4: release bank 0 with toggling downstream ready
      exp_free.push_back(0);
      beats = 0;
      for (int i = 0; i < 20 && beats < TILE; i++) begin
         rd_dat_vld = 1'b1;
         rd_dat_rdy = (i % 2 == 1);
         tick();
         if (i % 2 == 1) beats++;
         chk("t4_free_vld", free_vld, (i % 2 == 1 && beats == TILE) ? 1 : 0);
      end
      rd_dat_vld = 1'b0;
      rd_dat_rdy = 1'b0;
      chk("t4_tile_rdy_back", tile_rdy, 1);
      tick();
      chk("t4_pulse_one_cycle", free_vld, 0);

      // T5: accept and release (bank 1) in the same cycle
      for (int i = 0; i < TILE - 1; i++) begin
         rd_dat_vld = 1'b1;
         rd_dat_rdy = 1'b1;
         tick();
         chk("t5_no_early_free", free_vld, 0);
      end
      exp_free.push_back(1);
      push_tile(0);
      tile_vld = 1'b1;
      tick();
      tile_vld = 1'b0;
      rd_dat_vld = 1'b0;
      rd_dat_rdy = 1'b0;
      chk("t5_free_vld", free_vld, 1);
      chk("t5_tile_rdy", tile_rdy, 1);
      chk("t5_issue_vld", rd_req_vld, 1);
      chk("t5_issue_addr", rd_addr, 0);
      drain(n);
      chk("t5_tile_rdy_after", tile_rdy, 1);

      // T3: random stalls, one tile
      do_reset();
      rd_req_rdy = 1'b0;
      push_tile(0);
      tile_vld = 1'b1;
      tick();
      tile_vld = 1'b0;
      tick();
      n = 0;
      while (exp_addr.size() != 0 && n < 300) begin
         rd_req_rdy = ($urandom_range(0, 1) == 1);
         tick();
         n++;
      end
      chk("t3_drained", exp_addr.size(), 0);
      rd_req_rdy = 1'b1;

      // T6: reset mid-tile, restart, then a stray beat
      do_reset();
      push_tile(0);
      tile_vld = 1'b1;
      tick();
      tile_vld = 1'b0;
      tick();
      tick();
      chk("t6_third_addr", rd_addr, 1);
      rst = 1'b1;
      exp_addr.delete();
      exp_last.delete();
      tick();
      chk("t6_rst_vld", rd_req_vld, 0);
      chk("t6_rst_addr", rd_addr, 0);
      chk("t6_rst_free", free_vld, 0);
      chk("t6_rst_err", err, 0);
      rst = 1'b0;
      tick();
      chk("t6_no_free_after_rst", free_vld, 0);
      push_tile(0);
      tile_vld = 1'b1;
      tick();
      tile_vld = 1'b0;
      chk("t6_restart_addr", rd_addr, 0);
      drain(n);
      chk("t6_err_clear", err, 0);
      exp_free.push_back(0);
      for (int i = 0; i < TILE; i++) begin
         rd_dat_vld = 1'b1;
         rd_dat_rdy = 1'b1;
         tick();
      end
      rd_dat_vld = 1'b0;
      chk("t6_release", free_vld, 1);
      tick();
      rd_dat_vld = 1'b1;
      tick();
      rd_dat_vld = 1'b0;
      rd_dat_rdy = 1'b0;
      chk("t6_err_set", err, 1);
      chk("t6_stray_no_free", free_vld, 0);
      tick();
      chk("t6_err_sticky", err, 1);
      chk("free_left", exp_free.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
